// File: rtl/pll_reconfig_pkg.sv
// pll_reconfig_seq shared definitions: register map, counter fields,
// sequencer state encoding and error codes.
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE   = 6'h00;
    localparam logic [5:0] ADDR_STATUS = 6'h01;
    localparam logic [5:0] ADDR_START  = 6'h02;
    localparam logic [5:0] ADDR_N      = 6'h03;
    localparam logic [5:0] ADDR_M      = 6'h04;
    localparam logic [5:0] ADDR_C      = 6'h05;
    localparam logic [5:0] ADDR_DPS    = 6'h06;

    localparam int F_LO   = 0;
    localparam int F_HI   = 8;
    localparam int F_BYP  = 16;
    localparam int F_ODD  = 17;
    localparam int F_CSEL = 18;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_POLL = 2'd1;
    localparam logic [1:0] ERR_LOCK = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_MODE,
        S_WR_N,
        S_WR_M,
        S_WR_C,
        S_WR_DPS,
        S_START,
        S_POLL,
        S_LOCK
    } state_t;

endpackage

// File: rtl/pll_reconfig_seq_if.sv
// Avalon-MM management bus between the sequencer and the PLL
// reconfiguration core.
interface pll_reconfig_seq_if;
    import pll_reconfig_pkg::*;

    logic [5:0]  mgmt_address;
    logic        mgmt_read;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
        input  mgmt_readdata, mgmt_waitrequest
    );

    modport slave (
        input  mgmt_address, mgmt_read, mgmt_write, mgmt_writedata,
        output mgmt_readdata, mgmt_waitrequest
    );

endinterface

// File: rtl/mgmt_xfer.sv
// Single-transfer Avalon-MM master: registers one request onto the bus
// and holds it through waitrequest until the slave accepts it.
module mgmt_xfer
    import pll_reconfig_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               rd,
    input  logic [5:0]         addr,
    input  logic [31:0]        wdata,
    output logic               ack,
    output logic [31:0]        rdata,
    pll_reconfig_seq_if.master bus
);

    logic active;
    logic orphan;

    assign active = bus.mgmt_read | bus.mgmt_write;
    // A transfer abandoned by its requester must still finish on the bus,
    // but its completion must never be credited to the next requester.
    assign ack    = active & ~bus.mgmt_waitrequest & req & ~orphan;
    assign rdata  = bus.mgmt_readdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mgmt_read      <= 1'b0;
            bus.mgmt_write     <= 1'b0;
            bus.mgmt_address   <= '0;
            bus.mgmt_writedata <= '0;
            orphan             <= 1'b0;
        end else if (active) begin
            if (!bus.mgmt_waitrequest) begin
                bus.mgmt_read  <= 1'b0;
                bus.mgmt_write <= 1'b0;
                orphan         <= 1'b0;
            end else if (!req) begin
                orphan <= 1'b1;
            end
        end else if (req) begin
            bus.mgmt_read    <= rd;
            bus.mgmt_write   <= ~rd;
            bus.mgmt_address <= addr;
            if (!rd) begin
                bus.mgmt_writedata <= wdata;
            end
        end
    end

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: programs M/N/C (and DPS when
// PLL_RECONFIG_DPS_EN is defined), triggers, polls, then waits for relock.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int NCNT         = 3,
    parameter int POLL_TIMEOUT = 4096,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [17:0]        cfg_m,
    input  logic [17:0]        cfg_n,
    input  logic [NCNT*18-1:0] cfg_c,
`ifdef PLL_RECONFIG_DPS_EN
    input  logic [4:0]         dps_cnt,
    input  logic               dps_up,
    input  logic [15:0]        dps_num,
`endif
    input  logic               pll_locked,
    pll_reconfig_seq_if.master mgmt,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code
);

    state_t             state, state_d;
    logic [17:0]        m_q, m_d, n_q, n_d;
    logic [NCNT*18-1:0] c_q, c_d;
    logic [4:0]         cidx, cidx_d;
    logic [31:0]        cnt, cnt_d;
    logic               lock_q, lock_d;
    logic               busy_d, done_d, error_d;
    logic [1:0]         err_d;
    logic               req, rd, ack;
    logic [5:0]         addr;
    logic [31:0]        wdata, rdata;
    state_t             after_c;
`ifdef PLL_RECONFIG_DPS_EN
    logic [21:0]        dps_q, dps_d;
`endif

    logic unused_rdata;
    assign unused_rdata = ^rdata[31:1];

`ifdef PLL_RECONFIG_DPS_EN
    assign after_c = (dps_q[15:0] != 16'd0) ? S_WR_DPS : S_START;
`else
    assign after_c = S_START;
`endif

    mgmt_xfer u_xfer (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .rd    (rd),
        .addr  (addr),
        .wdata (wdata),
        .ack   (ack),
        .rdata (rdata),
        .bus   (mgmt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            m_q      <= '0;
            n_q      <= '0;
            c_q      <= '0;
            cidx     <= '0;
            cnt      <= '0;
            lock_q   <= 1'b0;
`ifdef PLL_RECONFIG_DPS_EN
            dps_q    <= '0;
`endif
        end else begin
            state    <= state_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            err_code <= err_d;
            m_q      <= m_d;
            n_q      <= n_d;
            c_q      <= c_d;
            cidx     <= cidx_d;
            cnt      <= cnt_d;
            lock_q   <= lock_d;
`ifdef PLL_RECONFIG_DPS_EN
            dps_q    <= dps_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        busy_d  = busy;
        done_d  = 1'b0;
        error_d = 1'b0;
        err_d   = err_code;
        m_d     = m_q;
        n_d     = n_q;
        c_d     = c_q;
        cidx_d  = cidx;
        cnt_d   = cnt;
        lock_d  = 1'b0;
        req     = 1'b0;
        rd      = 1'b0;
        addr    = ADDR_MODE;
        wdata   = '0;
`ifdef PLL_RECONFIG_DPS_EN
        dps_d   = dps_q;
`endif
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    m_d     = cfg_m;
                    n_d     = cfg_n;
                    c_d     = cfg_c;
                    cidx_d  = '0;
                    err_d   = ERR_NONE;
                    busy_d  = 1'b1;
                    state_d = S_MODE;
`ifdef PLL_RECONFIG_DPS_EN
                    dps_d   = {dps_up, dps_cnt, dps_num};
`endif
                end
            end
            S_MODE: begin
                req   = 1'b1;
                wdata = 32'd1;
                if (ack) state_d = S_WR_N;
            end
            S_WR_N: begin
                req   = 1'b1;
                addr  = ADDR_N;
                wdata = 32'(n_q);
                if (ack) state_d = S_WR_M;
            end
            S_WR_M: begin
                req   = 1'b1;
                addr  = ADDR_M;
                wdata = 32'(m_q);
                if (ack) state_d = S_WR_C;
            end
            S_WR_C: begin
                req   = 1'b1;
                addr  = ADDR_C;
                wdata = (32'(cidx) << F_CSEL) | 32'(c_q[17:0]);
                // Channel k is always in the low 18 bits of the shifted copy.
                if (ack) begin
                    c_d    = c_q >> 18;
                    cidx_d = cidx + 5'd1;
                    if (cidx == 5'(NCNT - 1)) state_d = after_c;
                end
            end
`ifdef PLL_RECONFIG_DPS_EN
            S_WR_DPS: begin
                req   = 1'b1;
                addr  = ADDR_DPS;
                wdata = 32'(dps_q);
                if (ack) state_d = S_START;
            end
`endif
            S_START: begin
                req  = 1'b1;
                addr = ADDR_START;
                if (ack) begin
                    state_d = S_POLL;
                    cnt_d   = '0;
                end
            end
            S_POLL: begin
                req  = 1'b1;
                rd   = 1'b1;
                addr = ADDR_STATUS;
                if (ack && rdata[0]) begin
                    state_d = S_LOCK;
                    cnt_d   = '0;
                end else if (cnt == 32'(POLL_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    err_d   = ERR_POLL;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            S_LOCK: begin
                lock_d = pll_locked;
                if (pll_locked && lock_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt == 32'(LOCK_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    err_d   = ERR_LOCK;
                end else begin
                    cnt_d = cnt + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq with a stalling Avalon slave
// and a transfer-list reference model.
module tb_pll_reconfig_seq;

    localparam int NCNT = 3;
    localparam int PT   = 16;
    localparam int LT   = 32;

    typedef struct {
        logic        rd;
        logic [5:0]  a;
        logic [31:0] d;
        int          t;
    } xfer_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [17:0]        cfg_m = '0;
    logic [17:0]        cfg_n = '0;
    logic [NCNT*18-1:0] cfg_c = '0;
    logic               pll_locked = 1'b0;
    logic               busy, done, error;
    logic [1:0]         err_code;
`ifdef PLL_RECONFIG_DPS_EN
    logic [4:0]         dps_cnt = '0;
    logic               dps_up = 1'b0;
    logic [15:0]        dps_num = '0;
`endif

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    t_start = 0;
    int    err_t = 0;
    int    n_done = 0;
    int    n_err = 0;
    int    nwr = 0;
    int    max_stall = 0;
    int    stall = 0;
    int    lock_cd = -1;
    logic  status_val = 1'b0;
    logic  lock_en = 1'b0;
    logic  wr = 1'b0;
    logic  in_x = 1'b0;
    xfer_t cur;
    xfer_t log_q[$];
    xfer_t exp_q[$];

    pll_reconfig_seq_if bus ();

    assign bus.mgmt_waitrequest = wr;
    assign bus.mgmt_readdata    = {31'd0, status_val};

    pll_reconfig_seq #(
        .NCNT         (NCNT),
        .POLL_TIMEOUT (PT),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_m      (cfg_m),
        .cfg_n      (cfg_n),
        .cfg_c      (cfg_c),
`ifdef PLL_RECONFIG_DPS_EN
        .dps_cnt    (dps_cnt),
        .dps_up     (dps_up),
        .dps_num    (dps_num),
`endif
        .pll_locked (pll_locked),
        .mgmt       (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: random stalls, stability checks, completed-transfer log.
    always @(negedge clk) begin
        if (!lock_en) begin
            pll_locked = 1'b0;
            lock_cd    = -1;
        end else if (lock_cd == 0) begin
            pll_locked = 1'b1;
        end else if (lock_cd > 0) begin
            lock_cd--;
        end
        if (bus.mgmt_read || bus.mgmt_write) begin
            chk("rd_wr_excl", {bus.mgmt_read, bus.mgmt_write} == 2'b11, 0);
            if (!in_x) begin
                in_x  = 1'b1;
                stall = $urandom_range(0, max_stall);
                cur.rd = bus.mgmt_read;
                cur.a  = bus.mgmt_address;
                cur.d  = bus.mgmt_read ? 32'd0 : bus.mgmt_writedata;
            end else begin
                chk("stall_stable",
                    {bus.mgmt_read, bus.mgmt_address,
                     bus.mgmt_read ? 32'd0 : bus.mgmt_writedata},
                    {cur.rd, cur.a, cur.d});
            end
            if (stall > 0) begin
                wr = 1'b1;
                stall--;
            end else begin
                wr    = 1'b0;
                in_x  = 1'b0;
                cur.t = cyc + 1;
                log_q.push_back(cur);
                if (cur.rd && status_val && lock_en) lock_cd = 5;
            end
        end else begin
            wr   = 1'b0;
            in_x = 1'b0;
        end
        if (done) n_done++;
        if (error) begin
            n_err++;
            err_t = cyc;
        end
    end

    task automatic push_exp(input logic r, input logic [5:0] a,
                            input logic [31:0] d);
        xfer_t e;
        e.rd = r;
        e.a  = a;
        e.d  = d;
        e.t  = 0;
        exp_q.push_back(e);
    endtask

    task automatic build(input int nreads);
        exp_q.delete();
        push_exp(0, 6'h00, 32'd1);
        push_exp(0, 6'h03, 32'(cfg_n));
        push_exp(0, 6'h04, 32'(cfg_m));
        for (int k = 0; k < NCNT; k++)
            push_exp(0, 6'h05, k * 262144 + 32'(cfg_c[18*k +: 18]));
`ifdef PLL_RECONFIG_DPS_EN
        if (dps_num != 0)
            push_exp(0, 6'h06, dps_up * 2097152 + dps_cnt * 65536 + dps_num);
`endif
        push_exp(0, 6'h02, 32'd0);
        nwr = exp_q.size();
        for (int k = 0; k < nreads; k++) push_exp(1, 6'h01, 32'd0);
    endtask

    task automatic cmp_log(input string tag);
        int n;
        chk({tag, "_count"}, log_q.size(), exp_q.size());
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk({tag, "_xfer"}, {log_q[i].rd, log_q[i].a, log_q[i].d},
                {exp_q[i].rd, exp_q[i].a, exp_q[i].d});
    endtask

    task automatic clr();
        log_q.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    task automatic go();
        @(negedge clk);
        start   = 1'b1;
        t_start = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int lim);
        int k;
        k = 0;
        while (!(done || error) && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_timeout"}, k >= lim, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_cfg();
        cfg_m = 18'($urandom);
        cfg_n = 18'($urandom);
        for (int k = 0; k < NCNT; k++) cfg_c[18*k +: 18] = 18'($urandom);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_strobes", {bus.mgmt_read, bus.mgmt_write}, 0);
        chk("rst_addr", bus.mgmt_address, 0);
        chk("rst_wdata", bus.mgmt_writedata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed reference configuration, no stalls.
        cfg_m = {1'b1, 1'b0, 8'd63, 8'd62};
        cfg_n = {2'b00, 8'd3, 8'd3};
        cfg_c = {18'h00101, 18'h00202, 18'h00202};
        status_val = 1'b1;
        lock_en    = 1'b1;
        max_stall  = 0;
        clr();
        build(1);
        go();
        chk("busy_after_start", busy, 1);
        wait_end("basic", 200);
        cmp_log("basic");
        if (log_q.size() >= nwr)
            chk("basic_latency", log_q[nwr-1].t - t_start, 2 * nwr);
        chk("basic_done", n_done, 1);
        chk("basic_noerr", n_err, 0);
        chk("basic_busy", busy, 0);
        chk("basic_errc", err_code, 0);

        // Random configurations with random stalls.
        max_stall = 7;
        for (int it = 0; it < 3; it++) begin
            rand_cfg();
            clr();
            build(1);
            go();
            wait_end("stall", 600);
            cmp_log("stall");
            chk("stall_done", n_done, 1);
        end
        max_stall = 0;

        // STATUS never reports completion.
        rand_cfg();
        status_val = 1'b0;
        lock_en    = 1'b0;
        clr();
        build(PT / 2);
        go();
        wait_end("poll", 200);
        cmp_log("poll");
        chk("poll_err", n_err, 1);
        chk("poll_nodone", n_done, 0);
        chk("poll_code", err_code, 1);
        chk("poll_time", err_t - t_start, 2 * nwr + PT);
        chk("poll_busy", busy, 0);

        // PLL never relocks, then a fresh start clears err_code.
        status_val = 1'b1;
        clr();
        go();
        wait_end("lock", 300);
        chk("lock_err", n_err, 1);
        chk("lock_nodone", n_done, 0);
        chk("lock_code", err_code, 2);
        lock_en = 1'b1;
        clr();
        build(1);
        go();
        chk("restart_clr", err_code, 0);
        wait_end("restart", 200);
        cmp_log("restart");
        chk("restart_done", n_done, 1);

        // Second start and cfg changes mid-sequence must be ignored.
        rand_cfg();
        clr();
        build(1);
        go();
        rand_cfg();
        repeat (6) @(negedge clk);
        chk("mid_busy", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rand_cfg();
        wait_end("mid", 200);
        cmp_log("mid");
        chk("mid_done", n_done, 1);
        repeat (10) @(negedge clk);
        chk("mid_no_replay", log_q.size(), exp_q.size());

        // Reset while polling, then a full replay.
        status_val = 1'b0;
        lock_en    = 1'b0;
        clr();
        build(1);
        go();
        k = 0;
        while (log_q.size() <= nwr && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_poll_reach", k >= 100, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_strobes", {bus.mgmt_read, bus.mgmt_write}, 0);
        chk("rst_mid_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        clr();
`ifdef PLL_RECONFIG_DPS_EN
        dps_num = 16'd5;
        dps_cnt = 5'd2;
        dps_up  = 1'b1;
`endif
        status_val = 1'b1;
        lock_en    = 1'b1;
        rand_cfg();
        build(1);
`ifdef PLL_RECONFIG_DPS_EN
        chk("dps_word", exp_q[3 + NCNT].d, 32'h220005);
`endif
        go();
        wait_end("replay", 200);
        cmp_log("replay");
        chk("replay_done", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_reconfig_seq.md
Name: pll_reconfig_seq

Overview:
- Avalon-MM master sequencer for the PLL reconfiguration core that drives the PLL's reconfig_to_pll/reconfig_from_pll buses.
- On a start pulse it latches a complete M/N/C counter set, writes it into the reconfig core's register map, triggers reconfiguration, polls for completion, then waits for PLL relock.
- Used to retune the 30.72 MHz-referenced system PLL (e.g. 160/160/320 MHz outputs) at run time from the control register block.

Parameters:
- NCNT, 3, number of C output counters programmed per sequence (1..18).
- POLL_TIMEOUT, 4096, maximum clk cycles spent polling the status register before error.
- LOCK_TIMEOUT, 65536, maximum clk cycles waiting for pll_locked after reconfiguration completes.

Ports:
- clk  in  1  system clock; also clocks the reconfig core's mgmt interface.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- cfg_m  in  18  M counter: [7:0] lo, [15:8] hi, [16] bypass, [17] odd-duty enable.
- cfg_n  in  18  N counter, same encoding as cfg_m.
- cfg_c  in  NCNT*18  C counters; channel k occupies [18k+17:18k], same encoding.
- pll_locked  in  1  PLL locked output, already synchronised to clk.
- mgmt_address  out  6  reconfig core register address.
- mgmt_read  out  1  read strobe.
- mgmt_write  out  1  write strobe.
- mgmt_writedata  out  32  write data.
- mgmt_readdata  in  32  read data, valid when mgmt_read=1 and mgmt_waitrequest=0.
- mgmt_waitrequest  in  1  Avalon stall.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at successful completion.
- error  out  1  one-cycle pulse at failure, issued in the same cycle as the err_code update.
- err_code  out  2  0 = none, 1 = poll timeout, 2 = lock timeout; held until the next accepted start.

Behaviour:
- Reset: all mgmt strobes 0, mgmt_address 0, mgmt_writedata 0, busy 0, done 0, error 0, err_code 0, FSM state IDLE. A reset asserted mid-sequence aborts immediately, with no further bus cycles.
- Avalon rules: strobe, address and data are held stable while mgmt_waitrequest=1. The transfer completes on the first cycle in which the strobe is 1 and waitrequest is 0. A new transfer starts no earlier than the following cycle. Read and write are never asserted together.
- Register map (word addresses): MODE 0x00, STATUS 0x01, START 0x02, N 0x03, M 0x04, C 0x05, DPS 0x06.
- States and transitions:
  - IDLE: on start=1, latch cfg_*, clear err_code, set busy, go to MODE. start while busy=1 is ignored.
  - MODE: write 0x00 <= 1 (polling mode).
  - WR_N: write 0x03 <= {14'b0, cfg_n}.
  - WR_M: write 0x04 <= {14'b0, cfg_m}.
  - WR_C: for k = 0..NCNT-1 in ascending order, write 0x05 <= {9'b0, k[4:0], cfg_c[k]}. Channel index k goes in bits [22:18].
  - WR_DPS (optional feature only; see below).
  - START: write 0x02 <= 0.
  - POLL: repeatedly read 0x01 until bit0=1.
    - Count cycles from POLL entry; if the count reaches POLL_TIMEOUT, take the error exit with err_code=1.
    - A read that completes with bit0=1 in the timeout cycle counts as success.
  - LOCK: wait for pll_locked=1 on two consecutive cycles.
    - Count cycles from LOCK entry; if the count reaches LOCK_TIMEOUT, take the error exit with err_code=2.
  - Success exit: pulse done for one cycle, clear busy, return to IDLE.
  - Error exit: pulse error for one cycle, clear busy, return to IDLE.
- Latency with waitrequest held 0: from start to the START write completing = 4+NCNT transfers, each taking 2 cycles (strobe cycle plus one idle cycle).
- Latched cfg values are used for the whole sequence; changes to cfg_* while busy have no effect.
- pll_locked is ignored outside the LOCK state.

Optional Feature:
- Macro PLL_RECONFIG_DPS_EN.
- When defined:
  - Extra inputs: dps_cnt[4:0] (counter select), dps_up (direction), dps_num[15:0] (number of shifts).
  - These are latched on start.
  - If dps_num != 0, state WR_DPS is inserted after WR_C and writes 0x06 <= {10'b0, dps_up, dps_cnt, dps_num}.
  - If dps_num == 0, WR_DPS is skipped.
- When not defined: the inputs do not exist and no address 0x06 access is ever issued.

Decomposition:
- Package pll_reconfig_pkg holds:
  - register address constants;
  - counter field offsets (LO 0, HI 8, BYP 16, ODD 17, CSEL 18);
  - FSM state enum;
  - err_code constants.
- Sub-module mgmt_xfer: a single-transfer Avalon master. Inputs req/rd/addr/wdata; outputs ack/rdata. It owns the waitrequest hold logic and is reused by every FSM state.

Test Plan:
- NCNT=3, waitrequest=0, cfg_m hi/lo 63/62 + odd, cfg_n 3/3, C=2/2, 2/2, 1/1; STATUS returns 1 on first read; pll_locked high 5 cycles later. Required writes in order: 0x00=1, 0x03=0x00303, 0x04=0x23F3E, 0x05=0x00202, 0x05=0x40202, 0x05=0x80101, 0x02=0. Then one read of 0x01, then done pulses once and busy falls.
- Random waitrequest stalls of 0-7 cycles on each transfer: address/data stable during every stall; same write sequence; no dropped or duplicated transfer.
- STATUS held at 0 with POLL_TIMEOUT=16: error pulses with err_code=1 within 16 cycles of POLL entry; no done.
- pll_locked never asserts, LOCK_TIMEOUT=32: error pulses with err_code=2. A following start clears err_code to 0.
- Second start pulse during WR_C, and cfg_c changed mid-sequence: ignored; written values equal the first latched set.
- rst asserted during POLL: next cycle all strobes 0 and busy 0; a fresh start replays the full sequence from MODE. With PLL_RECONFIG_DPS_EN, dps_num=5, dps_cnt=2, dps_up=1: 0x06 is written with 0x220005.
